// File: rtl/fifo_rd_stream.sv
// Read-side adapter that turns sync_fifo's one-cycle-latency read port into a bubble-free valid/ready stream.
// Optional beat counter on the stream side is enabled with `define FIFO_RD_BEAT_CNT_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  sclr_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_level
`ifdef FIFO_RD_BEAT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

  logic [DATA_WIDTH-1:0] buf_r [2];
  logic                  head_r;
  logic                  tail_r;
  logic [1:0]            level_r;
  logic                  inflight_r;
  logic                  pop_s;
  logic [2:0]            occ_s;

  assign m_valid   = (level_r != 2'd0);
  assign m_data    = buf_r[head_r];
  assign buf_level = level_r;
  assign pop_s     = m_valid && m_ready;

  // Occupancy after this cycle counts the beat already in flight, so reads stop before the buffer could overflow.
  assign occ_s      = {1'b0, level_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign fifo_rd_en = aclr_n && sclr_n && !fifo_empty && (occ_s < 3'd2);

  // Buffer, pointers, level and in-flight tracking.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      buf_r[0]   <= '0;
      buf_r[1]   <= '0;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      level_r    <= 2'd0;
      inflight_r <= 1'b0;
    end else if (!sclr_n) begin
      buf_r[0]   <= '0;
      buf_r[1]   <= '0;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      level_r    <= 2'd0;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= fifo_rd_en;
      if (inflight_r) begin
        buf_r[tail_r] <= fifo_dout;
        tail_r        <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      level_r <= level_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

`ifdef FIFO_RD_BEAT_CNT_EN
  // Accepted-beat counter, wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      beat_cnt <= '0;
    end else if (!sclr_n) begin
      beat_cnt <= '0;
    end else if (pop_s) begin
      beat_cnt <= beat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      beat_cnt <= beat_cnt;
    end
  end
`else
  // CNT_WIDTH only sizes the optional counter; reference it so the default build stays clean.
  logic unused_cnt_width_s;
  assign unused_cnt_width_s = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural sync_fifo read-port model.
module tb_fifo_rd_stream;
  logic       clk;
  logic       aclr_n;
  logic       sclr_n;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] buf_level;
`ifdef FIFO_RD_BEAT_CNT_EN
  logic [15:0] beat_cnt;
`endif

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .buf_level(buf_level)
`ifdef FIFO_RD_BEAT_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  bit         empty_gate;
  bit         force_ne;
  int         n_rd;
  int         tests;
  int         fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sync_fifo read port: dout is registered one cycle after rd_en
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      n_rd <= n_rd + 1;
      if (src_q.size() != 0) fifo_dout <= src_q.pop_front();
      else fifo_dout <= 8'hEE;
    end
  end

  task automatic step(input bit rdy);
    @(negedge clk);
    m_ready = rdy;
    fifo_empty = force_ne ? 1'b0 : ((src_q.size() == 0) || empty_gate);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", m_valid); end
    tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL rst_data got %h want 00", m_data); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en got %b want 0", fifo_rd_en); end
    tests++; if (buf_level !== 2'd0) begin fails++; $display("FAIL rst_level got %0d want 0", buf_level); end
`ifdef FIFO_RD_BEAT_CNT_EN
    tests++; if (beat_cnt !== 16'd0) begin fails++; $display("FAIL rst_beat got %0d want 0", beat_cnt); end
`endif
    @(negedge clk);
    aclr_n = 1'b1;
    #1;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rel_valid got %b want 0", m_valid); end
    tests++; if (buf_level !== 2'd0) begin fails++; $display("FAIL rel_level got %0d want 0", buf_level); end
    force_ne = 1'b0;
    fifo_empty = 1'b1;
    #1;
  endtask

  task automatic test_single;
    int rd_cyc = -1, v_cyc = -1, rd_cnt = 0, v_cnt = 0;
    logic [7:0] e;
    src_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    for (int c = 0; c < 10; c++) begin
      step(1'b1);
      if (fifo_rd_en) begin rd_cnt++; rd_cyc = c; end
      if (m_valid) begin
        v_cnt++; v_cyc = c;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        tests++; if (m_data !== e) begin fails++; $display("FAIL single_data got %h want %h", m_data, e); end
      end
    end
    tests++; if (rd_cnt != 1) begin fails++; $display("FAIL single_rd_cnt got %0d want 1", rd_cnt); end
    tests++; if (v_cnt != 1) begin fails++; $display("FAIL single_valid_cnt got %0d want 1", v_cnt); end
    tests++; if (v_cyc != rd_cyc + 2) begin fails++; $display("FAIL single_latency got %0d want %0d", v_cyc, rd_cyc + 2); end
    tests++; if (buf_level !== 2'd0) begin fails++; $display("FAIL single_level got %0d want 0", buf_level); end
  endtask

  task automatic test_stream;
    int first = -1, last = -1, v_cnt = 0, rd0;
    logic [7:0] e;
    rd0 = n_rd;
    for (int i = 0; i < 8; i++) begin src_q.push_back(8'(i)); exp_q.push_back(8'(i)); end
    for (int c = 0; c < 16; c++) begin
      step(1'b1);
      if (m_valid) begin
        v_cnt++; last = c;
        if (first < 0) first = c;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        tests++; if (m_data !== e) begin fails++; $display("FAIL stream_data got %h want %h", m_data, e); end
      end
    end
    tests++; if (v_cnt != 8) begin fails++; $display("FAIL stream_valid_cnt got %0d want 8", v_cnt); end
    tests++; if (last - first != 7) begin fails++; $display("FAIL stream_gap got span %0d want 7", last - first); end
    tests++; if (n_rd - rd0 != 8) begin fails++; $display("FAIL stream_rd_cnt got %0d want 8", n_rd - rd0); end
  endtask

  task automatic test_backpressure;
    int rd0;
    logic [7:0] e;
    rd0 = n_rd;
    for (int i = 0; i < 4; i++) begin src_q.push_back(8'h10 + 8'(i)); exp_q.push_back(8'h10 + 8'(i)); end
    repeat (6) step(1'b0);
    tests++; if (n_rd - rd0 != 2) begin fails++; $display("FAIL bp_rd_cnt got %0d want 2", n_rd - rd0); end
    tests++; if (buf_level !== 2'd2) begin fails++; $display("FAIL bp_level got %0d want 2", buf_level); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL bp_rd_en got %b want 0", fifo_rd_en); end
    tests++; if (m_data !== 8'h10) begin fails++; $display("FAIL bp_hold got %h want 10", m_data); end
    for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
      step(1'b1);
      if (m_valid) begin
        e = exp_q.pop_front();
        tests++; if (m_data !== e) begin fails++; $display("FAIL bp_data got %h want %h", m_data, e); end
      end
    end
    step(1'b1);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL bp_drain left %0d want 0", exp_q.size()); end
    tests++; if (buf_level !== 2'd0) begin fails++; $display("FAIL bp_end_level got %0d want 0", buf_level); end
  endtask

  task automatic test_sparse;
    int viol = 0, ovf = 0;
    bit rdy;
    logic [7:0] e;
    for (int i = 0; i < 20; i++) begin src_q.push_back(8'h40 + 8'(i)); exp_q.push_back(8'h40 + 8'(i)); end
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      empty_gate = ~empty_gate;
      rdy = 1'($urandom_range(0, 1));
      step(rdy);
      if (fifo_rd_en && fifo_empty) viol++;
      if (buf_level > 2'd2) ovf++;
      if (m_valid && m_ready) begin
        e = exp_q.pop_front();
        tests++; if (m_data !== e) begin fails++; $display("FAIL sparse_data got %h want %h", m_data, e); end
      end
    end
    empty_gate = 1'b0;
    tests++; if (viol != 0) begin fails++; $display("FAIL sparse_rd_on_empty got %0d want 0", viol); end
    tests++; if (ovf != 0) begin fails++; $display("FAIL sparse_level got %0d overflows want 0", ovf); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL sparse_timeout left %0d want 0", exp_q.size()); end
    repeat (3) step(1'b1);
  endtask

  task automatic test_flush;
    logic [7:0] e;
    src_q.push_back(8'h30); src_q.push_back(8'h31);
    step(1'b0);
    step(1'b0);
    tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL fl_rd_en got %b want 1", fifo_rd_en); end
    step(1'b0);
    tests++; if (buf_level !== 2'd1) begin fails++; $display("FAIL fl_pre_level got %0d want 1", buf_level); end
    sclr_n = 1'b0;
    src_q.push_back(8'h32);
    step(1'b1);
    tests++; if (buf_level !== 2'd0) begin fails++; $display("FAIL fl_level got %0d want 0", buf_level); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL fl_valid got %b want 0", m_valid); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL fl_rd_forced got %b want 0", fifo_rd_en); end
`ifdef FIFO_RD_BEAT_CNT_EN
    tests++; if (beat_cnt !== 16'd0) begin fails++; $display("FAIL fl_beat got %0d want 0", beat_cnt); end
`endif
    sclr_n = 1'b1;
    exp_q.push_back(8'h32);
    for (int c = 0; c < 8; c++) begin
      step(1'b1);
      if (m_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        tests++; if (m_data !== e) begin fails++; $display("FAIL fl_data got %h want %h", m_data, e); end
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL fl_resume left %0d want 0", exp_q.size()); end
  endtask

  initial begin
    tests = 0; fails = 0; n_rd = 0;
    empty_gate = 1'b0; force_ne = 1'b1;
    aclr_n = 1'b0; sclr_n = 1'b1; m_ready = 1'b1; fifo_empty = 1'b0;
    test_reset;
    test_single;
    test_stream;
    test_backpressure;
    test_sparse;
    test_flush;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Downstream read-side adapter for sync_fifo. It converts the FIFO's registered read port (rd_en, then dout valid the next cycle) into a valid/ready stream with full throughput and no bubbles. A 2-entry output buffer absorbs the one-cycle FIFO read latency, so downstream backpressure never loses data and never over-reads the FIFO. It sits between sync_fifo and any valid/ready consumer.

Parameters:
DATA_WIDTH, 8, width of fifo_dout and m_data
CNT_WIDTH, 16, width of beat_cnt; used only with FIFO_RD_BEAT_CNT_EN

Ports:
clk  input  1  single clock, rising edge
aclr_n  input  1  asynchronous active-low reset
sclr_n  input  1  synchronous active-low flush; drive it together with sync_fifo sclr_n
fifo_empty  input  1  sync_fifo empty flag
fifo_dout  input  DATA_WIDTH  sync_fifo dout; valid in the cycle after fifo_rd_en
fifo_rd_en  output  1  read strobe to sync_fifo rd_en
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  DATA_WIDTH  stream data, head of the output buffer
buf_level  output  2  occupied output-buffer entries, 0..2
beat_cnt  output  CNT_WIDTH  accepted beats; present only with FIFO_RD_BEAT_CNT_EN

Behaviour:
- One clock. Reset is asynchronous and active-low on aclr_n.
- aclr_n=0 clears immediately: buffer, buf_level=0, inflight=0, m_valid=0, m_data=0, fifo_rd_en=0, beat_cnt=0.
- sclr_n=0 sampled at a rising edge gives the same clear values after that edge. fifo_rd_en is forced to 0 combinationally while sclr_n=0.
- Internal state:
  - 2-entry FIFO buffer (head/tail pointers, 1 bit each).
  - buf_level (0..2).
  - inflight flag = fifo_rd_en registered.
- pop = m_valid && m_ready.
- m_valid = (buf_level != 0). It is driven from registers only.
- m_data = buffer[head]. It holds stable while m_valid && !m_ready.
- fifo_rd_en = sclr_n && !fifo_empty && ((buf_level + inflight - pop) < 2). Evaluate this in 3-bit arithmetic.
  - The combinational path m_ready -> fifo_rd_en is intentional and needed for 1 beat/cycle.
  - The consumer must not make m_ready depend on fifo_rd_en.
- Capture: when inflight=1, fifo_dout is written into buffer[tail] at the end of that cycle, and tail advances modulo 2.
- Level update each cycle: buf_level_next = buf_level + inflight - pop.
  - push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo 2.
- Latency: fifo_rd_en in cycle N -> fifo_dout valid in N+1 -> m_valid with that datum in N+2.
- Sustained throughput is 1 beat/cycle when fifo_empty=0 and m_ready=1.
- Invariant: buf_level + inflight <= 2 at all times, so the buffer never overflows.
- FIFO empty: fifo_rd_en is never 1 while fifo_empty=1. This relies on sync_fifo's empty being correct in the cycle it is sampled.
- Backpressure (m_ready=0): at most 2 entries are held plus 0 in flight. Once the buffer is full, reads stop.
- Flush mid-operation: a datum in flight during the sclr_n=0 cycle is discarded, as is all buffered data. The next read issues no earlier than the cycle after sclr_n returns to 1.
- Ordering is strictly FIFO; no data is duplicated or dropped except by reset or flush.

Optional Feature:
Macro FIFO_RD_BEAT_CNT_EN.
- Defined: beat_cnt port exists.
  - Increments by 1 on every pop.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - Cleared by aclr_n and sclr_n.
- Undefined: the beat_cnt port and its counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: aclr_n=0 with fifo_empty=0 and m_ready=1 -> m_valid=0, m_data=0, fifo_rd_en=0, buf_level=0 while asserted and on the first cycle after release (fifo_rd_en may then rise).
2. Single beat: model FIFO holds 0xA5 and m_ready=1 -> fifo_rd_en=1 for exactly one cycle N; m_valid=1 with m_data=0xA5 in N+2 only; buf_level returns to 0.
3. Streaming: model FIFO preloaded with 0x00..0x07 and m_ready=1 -> m_valid high 8 consecutive cycles carrying 0x00..0x07 in order; 8 fifo_rd_en pulses in total.
4. Backpressure: FIFO holds 0x10..0x13 and m_ready=0 -> exactly 2 reads issued, then buf_level=2, fifo_rd_en=0, m_data=0x10 held. Release m_ready -> 0x10, 0x11, 0x12, 0x13 delivered in order with no loss.
5. Sparse source: fifo_empty toggles every other cycle, random m_ready -> fifo_rd_en never 1 while fifo_empty=1; scoreboard order matches; buf_level never exceeds 2.
6. Flush in flight: sclr_n=0 in the cycle after fifo_rd_en, with buf_level=1 -> next cycle buf_level=0, m_valid=0, inflight datum never appears on m_data; with FIFO_RD_BEAT_CNT_EN, beat_cnt=0.
